// File: rtl/stage_sched_if.sv
// Handshake bundle between the top controller, the nonlinear unit and stage_sched.
// The landmark_num signal exists only when LANDMARK_NUM_IN_EN is defined.
interface stage_sched_if #(
  parameter int STAGE_NUM = 3,
  parameter int ROW_LEN   = 10
);
  logic [ROW_LEN-1:0]   l_k;
`ifdef LANDMARK_NUM_IN_EN
  logic [ROW_LEN-1:0]   landmark_num;
`endif
  logic [STAGE_NUM-1:0] stage_val;
  logic [STAGE_NUM-1:0] stage_rdy;
  logic [STAGE_NUM-1:0] nonlinear_s_val;
  logic [STAGE_NUM-1:0] nonlinear_m_rdy;
  logic [STAGE_NUM-1:0] nonlinear_m_val;
  logic [STAGE_NUM-1:0] nonlinear_s_rdy;
  logic [STAGE_NUM-1:0] stage_done;
  logic                 stage_err;
  logic                 busy;

  modport master (
`ifdef LANDMARK_NUM_IN_EN
    output landmark_num,
`endif
    output l_k, stage_val, nonlinear_s_val, nonlinear_s_rdy,
    input  stage_rdy, nonlinear_m_rdy, nonlinear_m_val, stage_done, stage_err, busy
  );

  modport slave (
`ifdef LANDMARK_NUM_IN_EN
    input  landmark_num,
`endif
    input  l_k, stage_val, nonlinear_s_val, nonlinear_s_rdy,
    output stage_rdy, nonlinear_m_rdy, nonlinear_m_val, stage_done, stage_err, busy
  );
endinterface

// File: rtl/stage_sched.sv
// Stage scheduler: accepts one one-hot stage, runs NL_IN -> CALC -> NL_OUT -> DONE.
// Optional LANDMARK_NUM_IN_EN adds a landmark_num range check on l_k at acceptance.
module stage_sched #(
  parameter int STAGE_NUM = 3,
  parameter int ROW_LEN   = 10,
  parameter int PIPE_LAT  = 8
) (
  input  logic          clk,
  input  logic          sys_rst,
  stage_sched_if.slave  sif
);
  localparam int CW = ROW_LEN + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NL_IN  = 3'd1,
    ST_CALC   = 3'd2,
    ST_NL_OUT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [STAGE_NUM-1:0] stage_q_r, stage_nxt_s;
  logic [ROW_LEN-1:0]   lk_q_r, lk_nxt_s;
  logic [CW-1:0]        cnt_r, calc_end_s;
  logic                 req_ok_s, req_bad_s, in_range_s, err_s;
  logic [STAGE_NUM-1:0] stage_rdy_r, m_rdy_r, m_val_r, done_r;
  logic                 err_r, busy_r;

  function automatic logic is_onehot(input logic [STAGE_NUM-1:0] v);
    return (v != {STAGE_NUM{1'b0}}) &&
           ((v & (v - STAGE_NUM'(1))) == {STAGE_NUM{1'b0}});
  endfunction

  // Request qualification in IDLE: exactly one-hot and, optionally, l_k in range
  always_comb begin
`ifdef LANDMARK_NUM_IN_EN
    in_range_s = (sif.l_k < sif.landmark_num);
`else
    in_range_s = 1'b1;
`endif
    req_ok_s  = is_onehot(sif.stage_val) && in_range_s;
    req_bad_s = (sif.stage_val != {STAGE_NUM{1'b0}}) && !req_ok_s;
  end

  // Last CALC cycle index; widened by one bit so lk_q at its maximum cannot wrap
  assign calc_end_s = {1'b0, lk_q_r} + CW'(PIPE_LAT - 1);

  // Next-state and captured-request logic
  always_comb begin
    state_nxt_s = state_r;
    stage_nxt_s = stage_q_r;
    lk_nxt_s    = lk_q_r;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_ok_s) begin
          state_nxt_s = ST_NL_IN;
          stage_nxt_s = sif.stage_val;
          lk_nxt_s    = sif.l_k;
        end else begin
          err_s = req_bad_s;
        end
      end
      ST_NL_IN: begin
        if (|(sif.nonlinear_s_val & stage_q_r)) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_NL_IN;
        end
      end
      ST_CALC: begin
        if (cnt_r == calc_end_s) begin
          state_nxt_s = ST_NL_OUT;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_NL_OUT: begin
        if (|(sif.nonlinear_s_rdy & stage_q_r)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_NL_OUT;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, captured request and CALC counter (counter is zero on every CALC entry)
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_r   <= ST_IDLE;
      stage_q_r <= {STAGE_NUM{1'b0}};
      lk_q_r    <= {ROW_LEN{1'b0}};
      cnt_r     <= {CW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      stage_q_r <= stage_nxt_s;
      lk_q_r    <= lk_nxt_s;
      if ((state_r == ST_CALC) && (state_nxt_s == ST_CALC)) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  // Outputs registered from the next state so each one lines up with its state
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      stage_rdy_r <= {STAGE_NUM{1'b1}};
      busy_r      <= 1'b0;
      m_rdy_r     <= {STAGE_NUM{1'b0}};
      m_val_r     <= {STAGE_NUM{1'b0}};
      done_r      <= {STAGE_NUM{1'b0}};
      err_r       <= 1'b0;
    end else begin
      stage_rdy_r <= (state_nxt_s == ST_IDLE)   ? {STAGE_NUM{1'b1}} : {STAGE_NUM{1'b0}};
      busy_r      <= (state_nxt_s != ST_IDLE);
      m_rdy_r     <= (state_nxt_s == ST_NL_IN)  ? stage_nxt_s : {STAGE_NUM{1'b0}};
      m_val_r     <= (state_nxt_s == ST_NL_OUT) ? stage_nxt_s : {STAGE_NUM{1'b0}};
      done_r      <= (state_nxt_s == ST_DONE)   ? stage_nxt_s : {STAGE_NUM{1'b0}};
      err_r       <= err_s;
    end
  end

  assign sif.stage_rdy       = stage_rdy_r;
  assign sif.busy            = busy_r;
  assign sif.nonlinear_m_rdy = m_rdy_r;
  assign sif.nonlinear_m_val = m_val_r;
  assign sif.stage_done      = done_r;
  assign sif.stage_err       = err_r;
endmodule

// File: tb/tb_stage_sched.sv
// Bench for stage_sched: directed vector table, reset sequences and random transactions
// checked cycle by cycle against a phase-boundary model of one transaction.
module tb_stage_sched;
  localparam int STAGE_NUM = 3;
  localparam int ROW_LEN   = 10;
  localparam int PIPE_LAT  = 8;

  logic clk = 1'b0;
  logic sys_rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  stage_sched_if #(.STAGE_NUM(STAGE_NUM), .ROW_LEN(ROW_LEN)) sif ();

  stage_sched #(.STAGE_NUM(STAGE_NUM), .ROW_LEN(ROW_LEN), .PIPE_LAT(PIPE_LAT)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .sif     (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sv;
    logic [9:0] lk;
    int         win;
    int         wout;
    logic       exp_err;
    int         exp_done;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One request from IDLE; win/wout = cycles the nonlinear unit withholds val/rdy.
  // Model: cycle t counts from the accepting edge; NL_IN 1..1+win, CALC next
  // lk+PIPE_LAT cycles, NL_OUT next wout+1 cycles, DONE one cycle, then IDLE.
  task automatic run_txn(input logic [2:0] sv, input logic [9:0] lk, input int win,
                         input int wout, output logic err_seen, output int done_seen);
    bit acc, bad;
    int n, done_t;
    bit in_nlin, in_nlout, in_done, in_idle;
    logic [13:0] exp_v, act_v;
    acc = ($countones(sv) == 1);
`ifdef LANDMARK_NUM_IN_EN
    if (lk >= sif.landmark_num) acc = 1'b0;
`endif
    bad = (sv != 3'b000) && !acc;
    done_seen = 0;
    sif.stage_val = sv;
    sif.l_k       = lk;
    @(posedge clk); #1;
    sif.stage_val = 3'b000;
    err_seen = sif.stage_err;
    if (!acc) begin
      chk("rej_err",  {31'b0, sif.stage_err}, {31'b0, bad});
      chk("rej_busy", {31'b0, sif.busy}, 32'd0);
      chk("rej_rdy",  {29'b0, sif.stage_rdy}, 32'd7);
      @(posedge clk); #1;
      chk("rej_err_pulse", {31'b0, sif.stage_err}, 32'd0);
    end else begin
      n      = int'(lk) + PIPE_LAT;
      done_t = 3 + win + n + wout;
      for (int t = 1; t <= done_t + 1; t++) begin
        in_nlin  = (t <= 1 + win);
        in_nlout = (t >= 2 + win + n) && (t <= 2 + win + n + wout);
        in_done  = (t == done_t);
        in_idle  = (t > done_t);
        exp_v = {in_idle ? 3'b111 : 3'b000, !in_idle,
                 in_nlin ? sv : 3'b000, in_nlout ? sv : 3'b000,
                 in_done ? sv : 3'b000, 1'b0};
        act_v = {sif.stage_rdy, sif.busy, sif.nonlinear_m_rdy, sif.nonlinear_m_val,
                 sif.stage_done, sif.stage_err};
        chk($sformatf("cyc%0d", t), {18'b0, act_v}, {18'b0, exp_v});
        if (sif.stage_done != 3'b000 && done_seen == 0) done_seen = t;
        sif.stage_val       = in_idle ? 3'b000 : 3'($urandom);
        sif.l_k             = 10'($urandom);
        sif.nonlinear_s_val = (~sv & 3'($urandom)) | ((t >= 1 + win) ? sv : 3'b000);
        sif.nonlinear_s_rdy = (~sv & 3'($urandom)) | ((t >= 2 + win + n + wout) ? sv : 3'b000);
        @(posedge clk); #1;
      end
      sif.nonlinear_s_val = 3'b000;
      sif.nonlinear_s_rdy = 3'b000;
    end
  endtask

  initial begin
    logic       e;
    int         d, cnt;
    logic [2:0] rsv;
    logic [9:0] rlk, lk_big;
    bit         racc;

    tbl[0] = '{3'b100, 10'd4, 0, 0,  1'b0, 15};
    tbl[1] = '{3'b011, 10'd0, 0, 0,  1'b1, 0};
    tbl[2] = '{3'b001, 10'd2, 5, 0,  1'b0, 18};
    tbl[3] = '{3'b010, 10'd0, 0, 10, 1'b0, 21};
    tbl[4] = '{3'b000, 10'd7, 0, 0,  1'b0, 0};
    tbl[5] = '{3'b111, 10'd3, 0, 0,  1'b1, 0};
    tbl[6] = '{3'b101, 10'd1, 0, 0,  1'b1, 0};
    tbl[7] = '{3'b110, 10'd2, 0, 0,  1'b1, 0};
    tbl[8] = '{3'b001, 10'd0, 0, 0,  1'b0, 11};
    tbl[9] = '{3'b010, 10'd1, 2, 3,  1'b0, 17};

    sys_rst = 1'b1;
    sif.stage_val = 3'b000;
    sif.l_k = 10'd0;
    sif.nonlinear_s_val = 3'b000;
    sif.nonlinear_s_rdy = 3'b000;
`ifdef LANDMARK_NUM_IN_EN
    sif.landmark_num = 10'h3FF;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",   {29'b0, sif.stage_rdy}, 32'd7);
    chk("rst_busy",  {31'b0, sif.busy}, 32'd0);
    chk("rst_mrdy",  {29'b0, sif.nonlinear_m_rdy}, 32'd0);
    chk("rst_mval",  {29'b0, sif.nonlinear_m_val}, 32'd0);
    chk("rst_done",  {29'b0, sif.stage_done}, 32'd0);
    chk("rst_err",   {31'b0, sif.stage_err}, 32'd0);
    sys_rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].sv, tbl[i].lk, tbl[i].win, tbl[i].wout, e, d);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
      chk($sformatf("vec%0d_done", i), d, tbl[i].exp_done);
    end

    // Largest l_k accepted in this build: CALC must run its full length without wrapping
`ifdef LANDMARK_NUM_IN_EN
    lk_big = 10'd1022;
`else
    lk_big = 10'd1023;
`endif
    run_txn(3'b001, lk_big, 0, 0, e, d);
    chk("big_done", d, 3 + int'(lk_big) + PIPE_LAT);

    // Reset in the middle of CALC
    sif.nonlinear_s_val = 3'b010;
    sif.stage_val = 3'b010;
    sif.l_k = 10'd5;
    @(posedge clk); #1;
    sif.stage_val = 3'b000;
    repeat (4) @(posedge clk);
    #1;
    chk("calc_busy", {31'b0, sif.busy}, 32'd1);
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    chk("midrst_rdy",  {29'b0, sif.stage_rdy}, 32'd7);
    chk("midrst_busy", {31'b0, sif.busy}, 32'd0);
    chk("midrst_done", {29'b0, sif.stage_done}, 32'd0);
    sif.nonlinear_s_val = 3'b111;
    sif.nonlinear_s_rdy = 3'b111;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (sif.stage_done != 3'b000 || sif.busy) cnt++;
    end
    chk("midrst_quiet", cnt, 0);
    sif.nonlinear_s_val = 3'b000;
    sif.nonlinear_s_rdy = 3'b000;

    // Request presented while reset is held is never taken
    sys_rst = 1'b1;
    sif.stage_val = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_noacc_busy", {31'b0, sif.busy}, 32'd0);
    chk("rst_noacc_err",  {31'b0, sif.stage_err}, 32'd0);
    sif.stage_val = 3'b000;
    sys_rst = 1'b0;
    @(posedge clk); #1;

`ifdef LANDMARK_NUM_IN_EN
    sif.landmark_num = 10'd6;
    run_txn(3'b001, 10'd6, 0, 0, e, d);
    chk("lm_rej_err",  {31'b0, e}, 32'd1);
    chk("lm_rej_done", d, 0);
    run_txn(3'b001, 10'd5, 0, 0, e, d);
    chk("lm_acc_done", d, 16);
    sif.landmark_num = 10'h3FF;
`endif

    for (int i = 0; i < 40; i++) begin
      rsv = 3'($urandom);
      rlk = 10'($urandom_range(0, 30));
      racc = ($countones(rsv) == 1);
      run_txn(rsv, rlk, $urandom_range(0, 3), $urandom_range(0, 3), e, d);
      chk($sformatf("rnd%0d_err", i), {31'b0, e},
          {31'b0, (rsv != 3'b000) && !racc});
      if (!racc) chk($sformatf("rnd%0d_nodone", i), d, 0);
      else chk($sformatf("rnd%0d_done_seen", i), {31'b0, (d > 0)}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stage_sched.md
STAGE_SCHED -- requirements
Module: stage_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter STAGE_NUM, default 3: number of one-hot stages; bit0=PRD, bit1=NEW, bit2=UPD, higher bits user stages.
REQ-003 Parameter ROW_LEN, default 10: width of l_k and landmark_num.
REQ-004 Parameter PIPE_LAT, default 8, legal >=1: fixed array drain cycles added to every compute phase.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: sys_rst  in  1  synchronous active-high reset.
REQ-007 Port: l_k  in  ROW_LEN  current landmark index; sampled at stage acceptance.
REQ-008 Port: landmark_num  in  ROW_LEN  map size (present only with LANDMARK_NUM_IN_EN).
REQ-009 Port: stage_val  in  STAGE_NUM  one-hot stage request from top controller.
REQ-010 Port: stage_rdy  out  STAGE_NUM  all ones when idle, else zero.
REQ-011 Port: nonlinear_s_val  in  STAGE_NUM  nonlinear unit has operands for the stage.
REQ-012 Port: nonlinear_m_rdy  out  STAGE_NUM  scheduler ready to take nonlinear operands.
REQ-013 Port: nonlinear_m_val  out  STAGE_NUM  array result valid to nonlinear unit.
REQ-014 Port: nonlinear_s_rdy  in  STAGE_NUM  nonlinear unit accepts result.
REQ-015 Port: stage_done  out  STAGE_NUM  one-cycle completion pulse, one-hot.
REQ-016 Port: stage_err  out  1  one-cycle pulse on rejected request.
REQ-017 Port: busy  out  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, NL_IN, CALC, NL_OUT, DONE; stage_q (STAGE_NUM) and lk_q (ROW_LEN) hold the active stage and l_k.
REQ-019 IDLE: stage_rdy all ones; a request is accepted at the edge where stage_val is exactly one-hot; stage_q<=stage_val, lk_q<=l_k, next state NL_IN.
REQ-020 IDLE with stage_val zero: remain IDLE; with stage_val multi-hot: no acceptance, stage_err=1 next cycle, remain IDLE.
REQ-021 NL_IN: nonlinear_m_rdy=stage_q; transfer when |(nonlinear_s_val & stage_q); next state CALC; bits of nonlinear_s_val outside stage_q are ignored.
REQ-022 CALC: counter (ROW_LEN+1 bits) cleared on entry; CALC SHALL last exactly lk_q+PIPE_LAT cycles, then NL_OUT; lk_q=0 gives PIPE_LAT cycles; no overflow for lk_q=2^ROW_LEN-1.
REQ-023 NL_OUT: nonlinear_m_val=stage_q held stable until |(nonlinear_s_rdy & stage_q); then DONE.
REQ-024 DONE: exactly one cycle, stage_done=stage_q, then IDLE; a new request is acceptable no earlier than the cycle after DONE.
REQ-025 nonlinear_m_rdy, nonlinear_m_val, stage_done SHALL be zero outside their state; stage_rdy SHALL be zero outside IDLE.
REQ-026 Latency from accepting edge to stage_done, zero handshake wait: 1+1+(lk_q+PIPE_LAT)+1 cycles to DONE entry.
REQ-027 stage_val, l_k changes while busy SHALL have no effect.

Reset
REQ-028 sys_rst high at a clock edge SHALL force IDLE, clear stage_q, lk_q, counter, from any state including mid-handshake.
REQ-029 Reset values: stage_rdy all ones, busy 0, nonlinear_m_rdy 0, nonlinear_m_val 0, stage_done 0, stage_err 0.
REQ-030 No request SHALL be accepted while sys_rst is high.

Configuration
REQ-031 Macro LANDMARK_NUM_IN_EN defined: landmark_num port exists; request with l_k >= landmark_num is rejected (stage_err pulse, remain IDLE).
REQ-032 Macro LANDMARK_NUM_IN_EN undefined: no landmark_num port, no range check; all other behaviour identical.

Verification (STAGE_NUM=3, PIPE_LAT=8, ROW_LEN=10)
REQ-033 stage_val=3'b100, l_k=4, s_val/s_rdy tied to 3'b100 -> CALC 12 cycles, stage_done=3'b100 for 1 cycle, 15 cycles after accepting edge.
REQ-034 stage_val=3'b011 -> no acceptance, stage_err pulse, stage_rdy stays 3'b111.
REQ-035 Accept 3'b001, nonlinear_s_val=3'b010 for 5 cycles then 3'b001 -> stays NL_IN until 3'b001, then CALC.
REQ-036 Hold nonlinear_s_rdy=0 for 10 cycles in NL_OUT -> nonlinear_m_val stable at stage_q throughout; done after rdy.
REQ-037 sys_rst pulse during CALC -> next cycle IDLE, stage_rdy=3'b111, no stage_done.
REQ-038 With LANDMARK_NUM_IN_EN, landmark_num=6, l_k=6 -> stage_err; l_k=5 -> accepted, CALC 13 cycles.
